// File: rtl/axil_timer_pkg.sv
// Shared constants for the AXI-Lite timer peripheral: register offsets,
// CTRL bit positions, response codes and the byte-strobe merge helper.
package axil_timer_pkg;

  // Register index, i.e. addr[4:2]
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;
  localparam int CTRL_AR = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Replace each byte of old_v whose strobe bit is set with the new byte
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// AXI-Lite responder front end. AW and W are captured into independent
// holding registers; once both are held a single-cycle register write strobe
// is issued and the B response raised. Reads are answered in the AR
// handshake cycle from a combinational register-file lookup.
module axil_reg_slave
  import axil_timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst,
  // write address
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr_i,
  input  logic                  s_axil_awvalid_i,
  output logic                  s_axil_awready_o,
  // write data
  input  logic [DATA_WIDTH-1:0] s_axil_wdata_i,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb_i,
  input  logic                  s_axil_wvalid_i,
  output logic                  s_axil_wready_o,
  // write response
  output logic [1:0]            s_axil_bresp_o,
  output logic                  s_axil_bvalid_o,
  input  logic                  s_axil_bready_i,
  // read address
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr_i,
  input  logic                  s_axil_arvalid_i,
  output logic                  s_axil_arready_o,
  // read data
  output logic [DATA_WIDTH-1:0] s_axil_rdata_o,
  output logic [1:0]            s_axil_rresp_o,
  output logic                  s_axil_rvalid_o,
  input  logic                  s_axil_rready_i,
  // register file write strobe
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [STRB_WIDTH-1:0] wr_strb_o,
  input  logic                  wr_err_i,
  // register file read port
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  rd_err_i
);

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic                  w_held_q,  w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q,   wstrb_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;

  // A channel only accepts while its holding slot is empty and no B is owed
  assign s_axil_awready_o = !aw_held_q && !bvalid_q;
  assign s_axil_wready_o  = !w_held_q  && !bvalid_q;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;

  // Only one read outstanding: a pending R blocks the next AR
  assign s_axil_arready_o = !rvalid_q;
  assign s_axil_rvalid_o  = rvalid_q;
  assign s_axil_rdata_o   = rdata_q;
  assign s_axil_rresp_o   = rresp_q;

  // bvalid masks the strobe so a held pair writes exactly once
  assign wr_en_o   = aw_held_q && w_held_q && !bvalid_q;
  assign wr_addr_o = awaddr_q;
  assign wr_data_o = wdata_q;
  assign wr_strb_o = wstrb_q;

  assign rd_en_o   = s_axil_arvalid_i && s_axil_arready_o;
  assign rd_addr_o = s_axil_araddr_i;

  // Write path next state: capture, respond, release on B handshake
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (s_axil_awvalid_i && s_axil_awready_o) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axil_awaddr_i;
    end
    if (s_axil_wvalid_i && s_axil_wready_o) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata_i;
      wstrb_d  = s_axil_wstrb_i;
    end
    if (wr_en_o) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err_i ? RESP_SLVERR : RESP_OKAY;
    end else if (bvalid_q && s_axil_bready_i) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  // Read path next state: register data at AR handshake, hold until rready
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rd_en_o) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_err_i ? '0 : rd_data_i;
      rresp_d  = rd_err_i ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && s_axil_rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; reset discards any held request without a response
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: rtl/axil_timer_irq.sv
// AXI-Lite timer peripheral: register file, prescaler, 32-bit counter with
// compare/auto-reload, and a level interrupt (pending & IE).
module axil_timer_irq
  import axil_timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  irq
);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  wr_err;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_err;

  logic [2:0]  ctrl_q,     ctrl_d;
  logic        pending_q,  pending_d;
  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pre_q,      pre_d;

  logic        tick;
  logic        match;
  logic        wr_hit;
  logic [31:0] merged;
  logic [31:0] ctrl_ext;
  logic [31:0] pre_ext;

  // Protection bits, byte offset and the read strobe carry no meaning here
  logic unused_sig;
  assign unused_sig = ^{s_axil_awprot, s_axil_arprot, wr_addr[1:0], rd_addr[1:0], rd_en};

  axil_reg_slave #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_slave (
    .clk              (clk),
    .rst              (rst),
    .s_axil_awaddr_i  (s_axil_awaddr),
    .s_axil_awvalid_i (s_axil_awvalid),
    .s_axil_awready_o (s_axil_awready),
    .s_axil_wdata_i   (s_axil_wdata),
    .s_axil_wstrb_i   (s_axil_wstrb),
    .s_axil_wvalid_i  (s_axil_wvalid),
    .s_axil_wready_o  (s_axil_wready),
    .s_axil_bresp_o   (s_axil_bresp),
    .s_axil_bvalid_o  (s_axil_bvalid),
    .s_axil_bready_i  (s_axil_bready),
    .s_axil_araddr_i  (s_axil_araddr),
    .s_axil_arvalid_i (s_axil_arvalid),
    .s_axil_arready_o (s_axil_arready),
    .s_axil_rdata_o   (s_axil_rdata),
    .s_axil_rresp_o   (s_axil_rresp),
    .s_axil_rvalid_o  (s_axil_rvalid),
    .s_axil_rready_i  (s_axil_rready),
    .wr_en_o          (wr_en),
    .wr_addr_o        (wr_addr),
    .wr_data_o        (wr_data),
    .wr_strb_o        (wr_strb),
    .wr_err_i         (wr_err),
    .rd_en_o          (rd_en),
    .rd_addr_o        (rd_addr),
    .rd_data_i        (rd_data),
    .rd_err_i         (rd_err)
  );

  // Valid window is 0x00..0x13; anything above, or aliased through upper bits, errors
  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    return (a[ADDR_WIDTH-1:5] != '0) || (a[4:2] > REG_PRESCALE);
  endfunction

  assign wr_err = addr_bad(wr_addr);
  assign rd_err = addr_bad(rd_addr);
  assign wr_hit = wr_en && !wr_err;

  assign tick  = ctrl_q[CTRL_EN] && (pre_q == prescale_q);
  assign match = tick && (count_q == compare_q);
  assign irq   = pending_q && ctrl_q[CTRL_IE];

  assign ctrl_ext = {29'd0, ctrl_q};
  assign pre_ext  = {16'd0, prescale_q};

  // Register read mux; unmapped addresses read as zero
  always_comb begin
    rd_data = '0;
    if (!rd_err) begin
      case (rd_addr[4:2])
        REG_CTRL:     rd_data = ctrl_ext;
        REG_STATUS:   rd_data = {31'd0, pending_q};
        REG_COUNT:    rd_data = count_q;
        REG_COMPARE:  rd_data = compare_q;
        REG_PRESCALE: rd_data = pre_ext;
        default:      rd_data = '0;
      endcase
    end
  end

  // Timer and register-file next state. Bus writes are applied after the
  // timer update so a written COUNT beats a tick; the pending set is applied
  // last so it beats a same-cycle W1C.
  always_comb begin
    ctrl_d     = ctrl_q;
    pending_d  = pending_q;
    count_d    = count_q;
    compare_d  = compare_q;
    prescale_d = prescale_q;
    pre_d      = pre_q;
    merged     = '0;

    if (ctrl_q[CTRL_EN]) pre_d = tick ? 16'd0 : pre_q + 16'd1;
    if (tick) count_d = (match && ctrl_q[CTRL_AR]) ? 32'd0 : count_q + 32'd1;

    if (wr_hit) begin
      case (wr_addr[4:2])
        REG_CTRL: begin
          merged = apply_strb(ctrl_ext, wr_data, wr_strb);
          ctrl_d = merged[2:0];
        end
        REG_STATUS: begin
          if (wr_strb[0] && wr_data[0]) pending_d = 1'b0;
        end
        REG_COUNT: begin
          count_d = apply_strb(count_q, wr_data, wr_strb);
        end
        REG_COMPARE: begin
          compare_d = apply_strb(compare_q, wr_data, wr_strb);
        end
        REG_PRESCALE: begin
          merged     = apply_strb(pre_ext, wr_data, wr_strb);
          prescale_d = merged[15:0];
          if (|wr_strb) pre_d = 16'd0;
        end
        default: ;
      endcase
    end

    if (match) pending_d = 1'b1;
  end

  // Timer/register state
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= 3'd0;
      pending_q  <= 1'b0;
      count_q    <= 32'd0;
      compare_q  <= COMPARE_RST;
      prescale_q <= 16'd0;
      pre_q      <= 16'd0;
    end else begin
      ctrl_q     <= ctrl_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      prescale_q <= prescale_d;
      pre_q      <= pre_d;
    end
  end

endmodule

// File: tb/tb_axil_timer_irq.sv
// Directed bench for axil_timer_irq: reset state, register access, strobes,
// address errors, timer/irq timing, set-vs-clear collision, reset mid-write.
module tb_axil_timer_irq;

  localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_CNT = 32'h08,
                          A_CMP  = 32'h0C, A_PRE  = 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axil_timer_irq dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full write: AW and W together, bready raised after both handshakes
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs, done;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; n = 0; done = 1'b0; resp = 2'bxx;
    while ((awvalid || wvalid) && n < 50) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    bready = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      if (bvalid) begin done = 1'b1; resp = bresp; end
      @(posedge clk); #1;
      n++;
    end
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_complete", {31'd0, done}, 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    logic hs;
    araddr = addr; arvalid = 1'b1; n = 0; hs = 1'b0;
    data = 'x; resp = 'x;
    while (!hs && n < 50) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1; n++;
    end
    arvalid = 1'b0; rready = 1'b1; hs = 1'b0;
    while (!hs && n < 50) begin
      @(negedge clk);
      if (rvalid) begin hs = 1'b1; data = rdata; resp = rresp; end
      @(posedge clk); #1; n++;
    end
    rready = 1'b0;
    chk("rd_complete", {31'd0, hs}, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr,
                        input logic [31:0] exp_d, input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    chk(tag, d, exp_d);
    chk({tag, "_rresp"}, {30'd0, r}, {30'd0, exp_r});
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] exp_r);
    logic [1:0] r;
    axi_write(addr, data, strb, r);
    chk({tag, "_bresp"}, {30'd0, r}, {30'd0, exp_r});
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_wready",  {31'd0, wready},  32'd1);
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_bresp",   {30'd0, bresp},   32'd0);
    chk("rst_rresp",   {30'd0, rresp},   32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    chk("rst_irq",     {31'd0, irq},     32'd0);
    @(posedge clk); #1;

    rd_chk("rst_compare",  A_CMP,  32'hFFFF_FFFF, 2'b00);
    rd_chk("rst_count",    A_CNT,  32'd0, 2'b00);
    rd_chk("rst_ctrl",     A_CTRL, 32'd0, 2'b00);
    rd_chk("rst_status",   A_STAT, 32'd0, 2'b00);
    rd_chk("rst_prescale", A_PRE,  32'd0, 2'b00);

    // Staggered write: AW now, W three cycles later, bready low for two cycles
    awaddr = A_CNT; awvalid = 1'b1;
    @(negedge clk); chk("stg_awready0", {31'd0, awready}, 32'd1);
    @(posedge clk); #1; awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stg_awready_held", {31'd0, awready}, 32'd0);
      chk("stg_bvalid_early", {31'd0, bvalid},  32'd0);
      @(posedge clk); #1;
    end
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); chk("stg_wready", {31'd0, wready}, 32'd1);
    @(posedge clk); #1; wvalid = 1'b0;
    @(negedge clk);
    chk("stg_bvalid_w_edge", {31'd0, bvalid},  32'd0);
    chk("stg_awready_w",     {31'd0, awready}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stg_bvalid_hold", {31'd0, bvalid},  32'd1);
      chk("stg_bresp",       {30'd0, bresp},   32'd0);
      chk("stg_awready_b",   {31'd0, awready}, 32'd0);
      chk("stg_wready_b",    {31'd0, wready},  32'd0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(negedge clk); chk("stg_bvalid_hs", {31'd0, bvalid}, 32'd1);
    @(posedge clk); #1; bready = 1'b0;
    @(negedge clk);
    chk("stg_bvalid_done",  {31'd0, bvalid},  32'd0);
    chk("stg_awready_back", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    rd_chk("stg_count_rb", A_CNT, 32'h1234_5678, 2'b00);

    // Byte strobes
    wr_chk("strb_cmp", A_CMP, 32'hAABB_CCDD, 4'b0010, 2'b00);
    rd_chk("strb_cmp_rb", A_CMP, 32'hFFFF_CCFF, 2'b00);
    wr_chk("strb0_cnt", A_CNT, 32'h0, 4'b0000, 2'b00);
    rd_chk("strb0_cnt_rb", A_CNT, 32'h1234_5678, 2'b00);
    wr_chk("strb_cnt_hi", A_CNT, 32'h9900_0000, 4'b1000, 2'b00);
    rd_chk("strb_cnt_hi_rb", A_CNT, 32'h9934_5678, 2'b00);

    // Address errors and reserved bits
    rd_chk("err_rd14", 32'h14, 32'd0, 2'b10);
    rd_chk("err_rd1c", 32'h1C, 32'd0, 2'b10);
    wr_chk("err_wr40", 32'h40, 32'hFFFF_FFFF, 4'hF, 2'b10);
    wr_chk("err_wr20", 32'h20, 32'h0000_0007, 4'hF, 2'b10);
    wr_chk("err_wr28", 32'h28, 32'h0000_0000, 4'hF, 2'b10);
    rd_chk("err_ctrl_kept", A_CTRL, 32'd0, 2'b00);
    rd_chk("err_cnt_kept",  A_CNT,  32'h9934_5678, 2'b00);
    rd_chk("err_rd_alias", 32'h8000_0008, 32'd0, 2'b10);
    wr_chk("ctrl_rsvd", A_CTRL, 32'hFFFF_FFF8, 4'hF, 2'b00);
    rd_chk("ctrl_rsvd_rb", A_CTRL, 32'd0, 2'b00);
    wr_chk("pre_hi", A_PRE, 32'hABCD_0003, 4'hF, 2'b00);
    rd_chk("pre_hi_rb", A_PRE, 32'h0000_0003, 2'b00);
    rd_chk("addr_lsb_ignored", 32'h13, 32'h0000_0003, 2'b00);

    // Timer: prescale 3, compare 2, auto-reload -> pending 12 clocks after enable
    wr_chk("tmr_cmp", A_CMP, 32'd2, 4'hF, 2'b00);
    wr_chk("tmr_cnt", A_CNT, 32'd0, 4'hF, 2'b00);
    wr_chk("tmr_ctrl", A_CTRL, 32'h7, 4'hF, 2'b00);
    // CTRL landed one edge before the write task returned
    chk("tmr_irq_early", {31'd0, irq}, 32'd0);
    cyc = 0;
    while (!irq && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    chk("tmr_irq_latency", cyc + 1, 32'd12);
    rd_chk("tmr_cnt_reload", A_CNT, 32'd0, 2'b00);
    rd_chk("tmr_status", A_STAT, 32'd1, 2'b00);
    wr_chk("tmr_stop", A_CTRL, 32'h2, 4'hF, 2'b00);
    chk("tmr_irq_level", {31'd0, irq}, 32'd1);
    wr_chk("tmr_w1c", A_STAT, 32'h1, 4'hF, 2'b00);
    chk("tmr_irq_cleared", {31'd0, irq}, 32'd0);
    rd_chk("tmr_status_clr", A_STAT, 32'd0, 2'b00);

    // Compare 0 with auto-reload and prescale 0: pending sets every clock
    wr_chk("col_pre", A_PRE, 32'd0, 4'hF, 2'b00);
    wr_chk("col_cmp", A_CMP, 32'd0, 4'hF, 2'b00);
    wr_chk("col_cnt", A_CNT, 32'd0, 4'hF, 2'b00);
    wr_chk("col_ctrl_noie", A_CTRL, 32'h5, 4'hF, 2'b00);
    rd_chk("col_status_noie", A_STAT, 32'd1, 2'b00);
    chk("col_irq_masked", {31'd0, irq}, 32'd0);
    wr_chk("col_ctrl_ie", A_CTRL, 32'h7, 4'hF, 2'b00);
    chk("col_irq_on", {31'd0, irq}, 32'd1);
    wr_chk("col_w1c", A_STAT, 32'h1, 4'hF, 2'b00);
    rd_chk("col_status_set_wins", A_STAT, 32'd1, 2'b00);
    chk("col_irq_kept", {31'd0, irq}, 32'd1);
    rd_chk("col_cnt_zero", A_CNT, 32'd0, 2'b00);
    wr_chk("col_stop", A_CTRL, 32'h2, 4'hF, 2'b00);
    wr_chk("col_w1c2", A_STAT, 32'h1, 4'hF, 2'b00);
    rd_chk("col_status_clr", A_STAT, 32'd0, 2'b00);
    chk("col_irq_off", {31'd0, irq}, 32'd0);

    // Reset while B is pending
    awaddr = A_CMP; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); chk("rstmid_bvalid_pre", {31'd0, bvalid}, 32'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rstmid_bvalid", {31'd0, bvalid},  32'd0);
    chk("rstmid_awready", {31'd0, awready}, 32'd1);
    chk("rstmid_wready", {31'd0, wready},  32'd1);
    @(posedge clk); #1;
    rd_chk("rstmid_cmp", A_CMP, 32'hFFFF_FFFF, 2'b00);

    // Reset while only AW is held: the address must be dropped
    awaddr = A_CNT; awvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1; wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk); chk("rstaw_no_b", {31'd0, bvalid}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    wr_chk("post_rst_wr", A_CNT, 32'hCAFE_0001, 4'hF, 2'b00);
    rd_chk("post_rst_rb", A_CNT, 32'hCAFE_0001, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
